// File: rtl/bit_cpt_chk.sv
// bit_cpt_chk: receive-side checker/decoder for a one-hot ring phase bus.
// It turns the phase into a binary index, counts completed rotations and
// flags illegal phase steps.
// Optional macro BIT_CPT_CHK_STRICT_EN: only phase N-1 -> 0 counts as a
// legal stop. Without it, any phase -> 0 is a legal stop.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   cpt_in    one-hot phase bus, bit0 = first phase
//   clr       synchronous clear of the error flag and rotation counter
//   phase_idx binary index of the current phase (holds the last legal one)
//   valid     phase_idx is tracking a legal non-zero phase
//   wrap      1-cycle pulse when the phase goes from N-1 back to 0
//   rot_cnt   completed-rotation count, wraps modulo 2**CNT_W
//   err       sticky error flag
//   err_code  first error cause: 00 none, 01 multi-hot, 10 illegal step
module bit_cpt_chk #(
    parameter int N     = 3,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     cpt_in,
    input  logic             clr,
    output logic [IDX_W-1:0] phase_idx,
    output logic             valid,
    output logic             wrap,
    output logic [CNT_W-1:0] rot_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR,
        SYNC
    } state_t;

    localparam logic [N-1:0] FIRST     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [1:0]   CODE_NONE = 2'b00;
    localparam logic [1:0]   CODE_MULT = 2'b01;
    localparam logic [1:0]   CODE_STEP = 2'b10;

    state_t           state;
    state_t           state_nx;
    logic [N-1:0]     prev;
    logic [N-1:0]     succ;
    logic             multi;
    logic [IDX_W-1:0] cur_idx;

    logic [IDX_W-1:0] idx_nx;
    logic             valid_nx;
    logic             wrap_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             err_nx;
    logic [1:0]       code_nx;

    // The only legal non-zero successor of a running phase is its
    // rotate-left neighbour.
    assign succ  = {prev[N-2:0], prev[N-1]};

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign multi = |(cpt_in & (cpt_in - FIRST));

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cpt_in[i]) begin
                cur_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = phase_idx;
        valid_nx = 1'b0;
        wrap_nx  = 1'b0;
        cnt_nx   = rot_cnt;
        err_nx   = err;
        code_nx  = err_code;

        unique case (state)
            IDLE: begin
                if (multi) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                    code_nx  = CODE_MULT;
                end else if (cpt_in == '0) begin
                    state_nx = IDLE;
                end else if (cpt_in == FIRST) begin
                    state_nx = RUN;
                    valid_nx = 1'b1;
                    idx_nx   = '0;
                end else begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                    code_nx  = CODE_STEP;
                end
            end
            RUN: begin
                if (multi) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                    code_nx  = CODE_MULT;
                end else if (cpt_in == succ) begin
                    state_nx = RUN;
                    valid_nx = 1'b1;
                    idx_nx   = cur_idx;
                    if (prev[N-1]) begin
                        wrap_nx = 1'b1;
                        cnt_nx  = rot_cnt + CNT_W'(1);
                    end
                end else if (cpt_in == '0) begin
`ifdef BIT_CPT_CHK_STRICT_EN
                    if (prev[N-1]) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = ERR;
                        err_nx   = 1'b1;
                        code_nx  = CODE_STEP;
                    end
`else
                    state_nx = IDLE;
`endif
                end else begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                    code_nx  = CODE_STEP;
                end
            end
            ERR: begin
                state_nx = ERR;
            end
            SYNC: begin
                if (cpt_in == '0) begin
                    state_nx = IDLE;
                end
            end
        endcase

        // Clear wins over anything detected in the same cycle; a non-zero
        // bus at clear time is mid-rotation, so resync on the next idle.
        if (clr) begin
            err_nx   = 1'b0;
            code_nx  = CODE_NONE;
            cnt_nx   = '0;
            valid_nx = 1'b0;
            wrap_nx  = 1'b0;
            idx_nx   = phase_idx;
            state_nx = (cpt_in == '0) ? IDLE : SYNC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            phase_idx <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            rot_cnt   <= '0;
            err       <= 1'b0;
            err_code  <= CODE_NONE;
        end else begin
            prev      <= cpt_in;
            phase_idx <= idx_nx;
            valid     <= valid_nx;
            wrap      <= wrap_nx;
            rot_cnt   <= cnt_nx;
            err       <= err_nx;
            err_code  <= code_nx;
        end
    end

endmodule

// File: tb/tb_bit_cpt_chk.sv
// tb_bit_cpt_chk: self-checking bench for bit_cpt_chk (N=3).
// Directed table, hand sequences for counter wrap and async reset, and
// randomized traffic against a rule-level reference model.
module tb_bit_cpt_chk;

    localparam int N = 3;

    logic       clk;
    logic       reset;
    logic [2:0] cpt_in;
    logic       clr;

    logic [1:0] phase_idx;
    logic       valid;
    logic       wrap;
    logic [7:0] rot_cnt;
    logic       err;
    logic [1:0] err_code;

    logic [1:0] b_idx;
    logic       b_valid;
    logic       b_wrap;
    logic [1:0] b_cnt;
    logic       b_err;
    logic [1:0] b_code;

    int n_chk = 0;
    int n_fail = 0;

    bit_cpt_chk #(.N(3), .IDX_W(2), .CNT_W(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpt_in    (cpt_in),
        .clr       (clr),
        .phase_idx (phase_idx),
        .valid     (valid),
        .wrap      (wrap),
        .rot_cnt   (rot_cnt),
        .err       (err),
        .err_code  (err_code)
    );

    bit_cpt_chk #(.N(3), .IDX_W(2), .CNT_W(2)) u_c2 (
        .clk       (clk),
        .reset     (reset),
        .cpt_in    (cpt_in),
        .clr       (clr),
        .phase_idx (b_idx),
        .valid     (b_valid),
        .wrap      (b_wrap),
        .rot_cnt   (b_cnt),
        .err       (b_err),
        .err_code  (b_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks mode flags and the previous sample.
    logic [2:0] m_prev;
    logic       m_err;
    logic [1:0] m_code;
    logic       m_sync;
    logic [1:0] m_idx;
    logic       m_valid;
    logic       m_wrap;
    int         m_cnt;

    task automatic model_rst();
        m_prev  = 3'b000;
        m_err   = 1'b0;
        m_code  = 2'b00;
        m_sync  = 1'b0;
        m_idx   = 2'd0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_fault(input logic [1:0] code);
        m_err   = 1'b1;
        m_code  = code;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] cur, input logic k);
        logic [2:0] nxt;
        nxt    = (m_prev == 3'b100) ? 3'b001 : (m_prev << 1);
        m_wrap = 1'b0;
        if (k) begin
            m_err   = 1'b0;
            m_code  = 2'b00;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_sync  = (cur != 3'b000);
        end else if (m_err) begin
            m_valid = 1'b0;
        end else if (m_sync) begin
            m_valid = 1'b0;
            if (cur == 3'b000) m_sync = 1'b0;
        end else if ($countones(cur) > 1) begin
            model_fault(2'b01);
        end else if (m_prev == 3'b000) begin
            if (cur == 3'b000) begin
                m_valid = 1'b0;
            end else if (cur == 3'b001) begin
                m_valid = 1'b1;
                m_idx   = 2'd0;
            end else begin
                model_fault(2'b10);
            end
        end else if (cur == 3'b000) begin
            m_valid = 1'b0;
`ifdef BIT_CPT_CHK_STRICT_EN
            if (m_prev != 3'b100) model_fault(2'b10);
`endif
        end else if (cur == nxt) begin
            m_valid = 1'b1;
            m_idx   = 2'($clog2(cur));
            if (m_prev == 3'b100) begin
                m_wrap = 1'b1;
                m_cnt  = m_cnt + 1;
            end
        end else begin
            model_fault(2'b10);
        end
        m_prev = cur;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want,
                     $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_idx,
                           input logic e_v, input logic e_w, input int e_cnt,
                           input logic e_e, input logic [1:0] e_code);
        chk({tag, ".idx"},   32'(phase_idx), 32'(e_idx));
        chk({tag, ".valid"}, 32'(valid),     32'(e_v));
        chk({tag, ".wrap"},  32'(wrap),      32'(e_w));
        chk({tag, ".cnt"},   32'(rot_cnt),   32'(e_cnt % 256));
        chk({tag, ".err"},   32'(err),       32'(e_e));
        chk({tag, ".code"},  32'(err_code),  32'(e_code));
        chk({tag, ".cnt2"},  32'(b_cnt),     32'(e_cnt % 4));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_idx, m_valid, m_wrap, m_cnt, m_err, m_code);
    endtask

    // One clock: drive at negedge, model on the edge, sample at negedge.
    task automatic cyc(input logic [2:0] c, input logic k);
        cpt_in = c;
        clr    = k;
        @(posedge clk);
        model_step(c, k);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        cpt_in = 3'b000;
        clr    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_rst();
    endtask

    typedef struct {
        logic [2:0] cur;
        logic       k;
        logic [1:0] idx;
        logic       v;
        logic       w;
        int         cnt;
        logic       e;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] cur, input logic k,
                       input logic [1:0] idx, input logic v, input logic w,
                       input int cnt, input logic e, input logic [1:0] code);
        vec_t r;
        r.cur = cur; r.k = k; r.idx = idx; r.v = v; r.w = w;
        r.cnt = cnt; r.e = e; r.code = code;
        tbl.push_back(r);
    endtask

    initial begin
        reset  = 1'b1;
        cpt_in = 3'b000;
        clr    = 1'b0;
        model_rst();

        add(3'b000, 0, 0, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 0, 0, 0, 2'b00);
        add(3'b010, 0, 1, 1, 0, 0, 0, 2'b00);
        add(3'b100, 0, 2, 1, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 1, 1, 0, 2'b00);
        add(3'b010, 0, 1, 1, 0, 1, 0, 2'b00);
        add(3'b100, 0, 2, 1, 0, 1, 0, 2'b00);
        add(3'b001, 0, 0, 1, 1, 2, 0, 2'b00);
        add(3'b010, 0, 1, 1, 0, 2, 0, 2'b00);
        add(3'b011, 0, 1, 0, 0, 2, 1, 2'b01);
        add(3'b110, 0, 1, 0, 0, 2, 1, 2'b01);
        add(3'b000, 1, 1, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 0, 0, 0, 2'b00);
        add(3'b100, 0, 0, 0, 0, 0, 1, 2'b10);
        add(3'b011, 0, 0, 0, 0, 0, 1, 2'b10);
        add(3'b000, 1, 0, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 0, 0, 0, 2'b00);
        add(3'b010, 0, 1, 1, 0, 0, 0, 2'b00);
`ifdef BIT_CPT_CHK_STRICT_EN
        add(3'b000, 0, 1, 0, 0, 0, 1, 2'b10);
`else
        add(3'b000, 0, 1, 0, 0, 0, 0, 2'b00);
`endif
        add(3'b000, 1, 1, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 0, 0, 0, 2'b00);
        add(3'b010, 0, 1, 1, 0, 0, 0, 2'b00);
        add(3'b010, 1, 1, 0, 0, 0, 0, 2'b00);
        add(3'b100, 0, 1, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 1, 0, 0, 0, 0, 2'b00);
        add(3'b000, 0, 1, 0, 0, 0, 0, 2'b00);
        add(3'b001, 0, 0, 1, 0, 0, 0, 2'b00);

        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 2'b00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cur, tbl[i].k);
            chk_all($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].v, tbl[i].w,
                    tbl[i].cnt, tbl[i].e, tbl[i].code);
        end

        // Five full rotations: narrow counter must read 1,2,3,0,1.
        for (int r = 1; r <= 5; r++) begin
            cyc(3'b010, 1'b0);
            cyc(3'b100, 1'b0);
            cyc(3'b001, 1'b0);
            chk($sformatf("rot%0d.cnt", r), 32'(rot_cnt), 32'(r));
            chk($sformatf("rot%0d.cnt2", r), 32'(b_cnt), 32'(r % 4));
            chk($sformatf("rot%0d.wrap", r), 32'(wrap), 32'd1);
        end

        // Asynchronous reset mid-phase clears outputs without a clock edge.
        cyc(3'b010, 1'b0);
        chk("mid.valid", 32'(valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        model_rst();
        cyc(3'b010, 1'b0);
        chk_all("post_rst", 0, 0, 0, 0, 1, 2'b10);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] c;
            logic       k;
            int         r;
            if (n % 1000 == 999) do_reset();
            r = $urandom_range(0, 99);
            if (r < 72) begin
                c = (m_prev == 3'b000) ? 3'b001 :
                    (m_prev == 3'b100) ? 3'b001 : (m_prev << 1);
                if (m_prev != 3'b001 && m_prev != 3'b010 &&
                    m_prev != 3'b100 && m_prev != 3'b000) c = 3'b000;
            end else if (r < 82) begin
                c = 3'b000;
            end else if (r < 88) begin
                c = m_prev;
            end else begin
                c = 3'($urandom_range(0, 7));
            end
            k = ($urandom_range(0, 99) < 3);
            cyc(c, k);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
